// File: rtl/led_sweep_pkg.sv
// Shared types and helpers for the LED bar-sweep generator.
// LED_SWEEP_BOUNCE_EN selects whether mode 2'b10 decodes to bounce or to right.
package led_sweep_pkg;

  typedef enum logic [1:0] {
    MODE_RIGHT  = 2'b00,
    MODE_LEFT   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  function automatic int cnt_width(input int width, input int trail);
    return $clog2(width + trail);
  endfunction

  // The reserved code, and bounce when it is not compiled in, collapse to right
  // so that mode-change detection sees only modes the hardware implements.
  function automatic mode_t decode_mode(input logic [1:0] raw);
    mode_t m;
    m = MODE_RIGHT;
    if (raw == MODE_LEFT) m = MODE_LEFT;
`ifdef LED_SWEEP_BOUNCE_EN
    if (raw == MODE_BOUNCE) m = MODE_BOUNCE;
`endif
    return m;
  endfunction

endpackage

// File: rtl/led_sweep_if.sv
// Control/status bundle between the mode mux and the LED bar-sweep generator.
interface led_sweep_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic             tick;
  logic [1:0]       mode;
  logic [WIDTH-1:0] led;
  logic             cycle_done;

  modport master (output enable, output tick, output mode, input led, input cycle_done);
  modport slave  (input enable, input tick, input mode, output led, output cycle_done);
endinterface

// File: rtl/led_bar_decode.sv
// Combinational decode of a bar position into the LED pattern.
// Left-to-right index k is lit when pos-TRAIL <= k <= pos-1; reverse mirrors it.
module led_bar_decode #(
  parameter int WIDTH = 4,
  parameter int TRAIL = 2,
  parameter int PW    = 3
) (
  input  logic [PW-1:0]    pos,
  input  logic             reverse,
  output logic [WIDTH-1:0] pattern
);

  always_comb begin
    pattern = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if ((int'(pos) >= k + 1) && (int'(pos) <= k + TRAIL)) begin
        if (reverse) pattern[k] = 1'b1;
        else         pattern[WIDTH-1-k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_sweep.sv
// WIDTH-LED, TRAIL-long bar sweep: right, left and (with LED_SWEEP_BOUNCE_EN) bounce.
// Holds the position counter, bounce direction, mode-change restart and period pulse.
module led_sweep
  import led_sweep_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int TRAIL = 2
) (
  input  logic       clk,
  input  logic       reset,
  led_sweep_if.slave bus
);

  localparam int PW = cnt_width(WIDTH, TRAIL);
  typedef logic [PW-1:0] pos_t;

  localparam pos_t POS_LAST  = pos_t'(WIDTH + TRAIL - 1);
  localparam pos_t POS_TRAIL = pos_t'(TRAIL);
  localparam pos_t POS_ONE   = pos_t'(1);
`ifdef LED_SWEEP_BOUNCE_EN
  localparam pos_t POS_FULL   = pos_t'(WIDTH);
  localparam pos_t POS_TRAIL1 = pos_t'(TRAIL + 1);
`endif

  pos_t             pos_q, pos_d;
  mode_t            mode_q, mode_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic             done_q, done_d;
`ifdef LED_SWEEP_BOUNCE_EN
  logic             dir_q, dir_d;
`endif

  logic             step;
  mode_t            mode_dec;
  logic [WIDTH-1:0] bar_pat;

  assign step     = bus.enable && bus.tick;
  assign mode_dec = decode_mode(bus.mode);

  always_comb begin
    pos_d  = pos_q;
    mode_d = mode_q;
    done_d = 1'b0;
`ifdef LED_SWEEP_BOUNCE_EN
    dir_d  = dir_q;
`endif
    if (step) begin
      mode_d = mode_dec;
      if (mode_dec != mode_q) begin
        pos_d = (mode_dec == MODE_BOUNCE) ? POS_TRAIL : '0;
`ifdef LED_SWEEP_BOUNCE_EN
        dir_d = 1'b0;
`endif
      end else if (pos_q > POS_LAST) begin
        pos_d = '0;
`ifdef LED_SWEEP_BOUNCE_EN
        dir_d = 1'b0;
      end else if (mode_dec == MODE_BOUNCE) begin
        // Bar stays fully on-screen; reflect at either end of TRAIL..WIDTH.
        if (WIDTH == TRAIL) begin
          pos_d = POS_TRAIL;
        end else if (!dir_q) begin
          if (pos_q >= POS_FULL) begin
            dir_d = 1'b1;
            pos_d = pos_q - POS_ONE;
          end else begin
            pos_d = pos_q + POS_ONE;
          end
        end else begin
          if (pos_q <= POS_TRAIL) begin
            dir_d = 1'b0;
            pos_d = pos_q + POS_ONE;
          end else begin
            pos_d  = pos_q - POS_ONE;
            done_d = (pos_q == POS_TRAIL1);
          end
        end
`endif
      end else if (pos_q == POS_LAST) begin
        pos_d  = '0;
        done_d = 1'b1;
      end else begin
        pos_d = pos_q + POS_ONE;
      end
    end
  end

  led_bar_decode #(
    .WIDTH (WIDTH),
    .TRAIL (TRAIL),
    .PW    (PW)
  ) u_decode (
    .pos     (pos_d),
    .reverse (mode_d == MODE_LEFT),
    .pattern (bar_pat)
  );

  // Pattern comes from next-pos so the LEDs move on the stepping edge itself.
  always_comb begin
    led_d = led_q;
    if (step) led_d = bar_pat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q  <= '0;
      mode_q <= MODE_RIGHT;
      led_q  <= '0;
      done_q <= 1'b0;
`ifdef LED_SWEEP_BOUNCE_EN
      dir_q  <= 1'b0;
`endif
    end else begin
      pos_q  <= pos_d;
      mode_q <= mode_d;
      led_q  <= led_d;
      done_q <= done_d;
`ifdef LED_SWEEP_BOUNCE_EN
      dir_q  <= dir_d;
`endif
    end
  end

  assign bus.led        = led_q;
  assign bus.cycle_done = done_q;

endmodule

// File: tb/tb_led_sweep.sv
// Self-checking bench for led_sweep (WIDTH=4, TRAIL=2): directed test-plan
// sequences plus randomized stimulus against a behavioural model.
module tb_led_sweep;

  localparam int W = 4;
  localparam int T = 2;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  led_sweep_if #(.WIDTH(W)) bus ();

  led_sweep #(.WIDTH(W), .TRAIL(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: sweep position 0..W+T-1, bounce as a triangle phase.
  int       m_pos;
  int       m_mode;
  int       m_phase;
  logic [W-1:0] m_led;
  logic     m_done;

  function automatic logic [W-1:0] bar(input int p, input bit rev);
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < W; k++)
      if (k >= p - T && k <= p - 1) begin
        if (rev) v[k] = 1'b1;
        else     v[W-1-k] = 1'b1;
      end
    return v;
  endfunction

  function automatic int eff_mode(input logic [1:0] md);
    if (md == 2'b01) return 1;
`ifdef LED_SWEEP_BOUNCE_EN
    if (md == 2'b10) return 2;
`endif
    return 0;
  endfunction

  task automatic model_step(input bit rst, input bit en, input bit tk, input logic [1:0] md);
    int dm;
    int span;
    m_done = 1'b0;
    if (rst) begin
      m_pos = 0; m_mode = 0; m_phase = 0; m_led = '0;
    end else if (en && tk) begin
      dm = eff_mode(md);
      span = 2 * (W - T);
      if (dm != m_mode) begin
        m_mode = dm; m_phase = 0;
        m_pos = (dm == 2) ? T : 0;
      end else if (dm == 2) begin
        if (span > 0) begin
          m_phase = (m_phase + 1) % span;
          m_done  = (m_phase == 0);
        end
        m_pos = T + ((m_phase <= W - T) ? m_phase : span - m_phase);
      end else begin
        m_pos  = (m_pos + 1) % (W + T);
        m_done = (m_pos == 0);
      end
      m_led = bar(m_pos, m_mode == 1);
    end
  endtask

  task automatic do_cyc(input bit rst, input bit en, input bit tk, input logic [1:0] md);
    reset = rst; bus.enable = en; bus.tick = tk; bus.mode = md;
    @(posedge clk);
    #1;
    reset = 1'b0; bus.tick = 1'b0;
  endtask

  task automatic test_reset();
    do_cyc(1, 0, 0, 2'b00);
    do_cyc(1, 1, 1, 2'b00);
    checks++;
    if (bus.led !== 4'b0000 || bus.cycle_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_values led=%b done=%b required led=0000 done=0", bus.led, bus.cycle_done);
    end
    do_cyc(0, 1, 0, 2'b00);
    checks++;
    if (bus.led !== 4'b0000 || bus.cycle_done !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_tick led=%b done=%b required led=0000 done=0", bus.led, bus.cycle_done);
    end
  endtask

  task automatic test_right();
    logic [3:0] exp_led [7] = '{4'b1000, 4'b1100, 4'b0110, 4'b0011, 4'b0001, 4'b0000, 4'b1000};
    do_cyc(1, 0, 0, 2'b00);
    for (int i = 0; i < 7; i++) begin
      do_cyc(0, 1, 1, 2'b00);
      checks++;
      if (bus.led !== exp_led[i] || bus.cycle_done !== (i == 5)) begin
        failures++;
        $display("FAIL right_tick%0d led=%b done=%b required led=%b done=%b",
                 i + 1, bus.led, bus.cycle_done, exp_led[i], (i == 5));
      end
    end
  endtask

  task automatic test_left();
    logic [3:0] exp_led [6] = '{4'b0001, 4'b0011, 4'b0110, 4'b1100, 4'b1000, 4'b0000};
    do_cyc(1, 0, 0, 2'b00);
    do_cyc(0, 1, 1, 2'b01);
    checks++;
    if (bus.led !== 4'b0000 || bus.cycle_done !== 1'b0) begin
      failures++;
      $display("FAIL left_restart led=%b done=%b required led=0000 done=0", bus.led, bus.cycle_done);
    end
    for (int i = 0; i < 6; i++) begin
      do_cyc(0, 1, 1, 2'b01);
      checks++;
      if (bus.led !== exp_led[i] || bus.cycle_done !== (i == 5)) begin
        failures++;
        $display("FAIL left_tick%0d led=%b done=%b required led=%b done=%b",
                 i + 1, bus.led, bus.cycle_done, exp_led[i], (i == 5));
      end
    end
  endtask

  task automatic test_enable_hold();
    do_cyc(1, 0, 0, 2'b00);
    do_cyc(0, 1, 1, 2'b00);
    do_cyc(0, 1, 1, 2'b00);
    for (int i = 0; i < 5; i++) begin
      do_cyc(0, 0, 1, 2'b00);
      checks++;
      if (bus.led !== 4'b1100 || bus.cycle_done !== 1'b0) begin
        failures++;
        $display("FAIL enable_hold%0d led=%b done=%b required led=1100 done=0",
                 i, bus.led, bus.cycle_done);
      end
    end
    do_cyc(0, 1, 1, 2'b00);
    checks++;
    if (bus.led !== 4'b0110 || bus.cycle_done !== 1'b0) begin
      failures++;
      $display("FAIL enable_resume led=%b done=%b required led=0110 done=0", bus.led, bus.cycle_done);
    end
  endtask

  task automatic test_mode_change();
    do_cyc(1, 0, 0, 2'b00);
    for (int i = 0; i < 3; i++) do_cyc(0, 1, 1, 2'b00);
    checks++;
    if (bus.led !== 4'b0110) begin
      failures++;
      $display("FAIL modechg_pre led=%b required 0110", bus.led);
    end
    do_cyc(0, 1, 1, 2'b01);
    checks++;
    if (bus.led !== 4'b0000 || bus.cycle_done !== 1'b0) begin
      failures++;
      $display("FAIL modechg_restart led=%b done=%b required led=0000 done=0", bus.led, bus.cycle_done);
    end
    do_cyc(0, 1, 1, 2'b01);
    checks++;
    if (bus.led !== 4'b0001) begin
      failures++;
      $display("FAIL modechg_next led=%b required 0001", bus.led);
    end
  endtask

  task automatic test_bounce();
`ifdef LED_SWEEP_BOUNCE_EN
    logic [3:0] exp_led [6] = '{4'b1100, 4'b0110, 4'b0011, 4'b0110, 4'b1100, 4'b0110};
    int done_at = 4;
`else
    logic [3:0] exp_led [6] = '{4'b1000, 4'b1100, 4'b0110, 4'b0011, 4'b0001, 4'b0000};
    int done_at = 5;
`endif
    do_cyc(1, 0, 0, 2'b00);
    for (int i = 0; i < 6; i++) begin
      do_cyc(0, 1, 1, 2'b10);
      checks++;
      if (bus.led !== exp_led[i] || bus.cycle_done !== (i == done_at)) begin
        failures++;
        $display("FAIL bounce_tick%0d led=%b done=%b required led=%b done=%b",
                 i + 1, bus.led, bus.cycle_done, exp_led[i], (i == done_at));
      end
    end
  endtask

  task automatic test_reset_step();
    do_cyc(1, 0, 0, 2'b00);
    for (int i = 0; i < 4; i++) do_cyc(0, 1, 1, 2'b00);
    checks++;
    if (bus.led !== 4'b0011) begin
      failures++;
      $display("FAIL rststep_pre led=%b required 0011", bus.led);
    end
    do_cyc(1, 1, 1, 2'b00);
    checks++;
    if (bus.led !== 4'b0000 || bus.cycle_done !== 1'b0) begin
      failures++;
      $display("FAIL rststep_blank led=%b done=%b required led=0000 done=0", bus.led, bus.cycle_done);
    end
    do_cyc(0, 1, 1, 2'b00);
    checks++;
    if (bus.led !== 4'b1000) begin
      failures++;
      $display("FAIL rststep_resume led=%b required 1000", bus.led);
    end
  endtask

  task automatic test_random();
    logic [1:0] md;
    bit rst, en, tk;
    md = 2'b00;
    model_step(1, 0, 0, md);
    do_cyc(1, 0, 0, md);
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      en  = ($urandom_range(0, 4) != 0);
      tk  = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 15) == 0) md = 2'($urandom_range(0, 3));
      model_step(rst, en, tk, md);
      do_cyc(rst, en, tk, md);
      checks++;
      if (bus.led !== m_led || bus.cycle_done !== m_done) begin
        failures++;
        $display("FAIL random_cyc%0d led=%b done=%b required led=%b done=%b",
                 i, bus.led, bus.cycle_done, m_led, m_done);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.tick = 1'b0;
    bus.mode = 2'b00;
    test_reset();
    test_right();
    test_left();
    test_enable_hold();
    test_mode_change();
    test_bounce();
    test_reset_step();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
